// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the system bus between master 1 and master 2.
// Registered one-hot grants, grant-hold watchdog, and a one-cycle turnaround
// between owners so the address/data muxes never see two drivers.
// Optional feature macro ARB_ROUND_ROBIN_EN: when defined, a tie goes to the
// master that did not own the bus last; when undefined, master 1 wins ties.
module bus_arbiter #(
  parameter int unsigned CNT_LEN = 16,
  parameter int unsigned TIMEOUT = 16'hFFFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req1,
  input  logic               req2,
  input  logic               done1,
  input  logic               done2,
  output logic               grant1,
  output logic               grant2,
  output logic [1:0]         master_sel,
  output logic               bus_busy,
  output logic               timeout,
  output logic [CNT_LEN-1:0] hold_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT1,
    GRANT2,
    TURNAROUND
  } state_t;

  // Watchdog fires on the last permitted grant cycle; TIMEOUT of 0 disables it.
  localparam bit                 WDOG_EN   = (TIMEOUT != 0);
  localparam int unsigned        TO_LAST32 = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CNT_LEN-1:0] TO_LAST   = CNT_LEN'(TO_LAST32);

  state_t             state_q, state_d;
  logic               last2_q, last2_d;     // 1: master 2 owned the bus last
  logic               grant1_q, grant1_d;
  logic               grant2_q, grant2_d;
  logic [1:0]         sel_q, sel_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic [CNT_LEN-1:0] hold_q, hold_d;
  logic               wd_hit;
  logic               tie_to_2;

  assign wd_hit = WDOG_EN && (hold_q == TO_LAST);

`ifdef ARB_ROUND_ROBIN_EN
  assign tie_to_2 = !last2_q;
`else
  // Fixed priority: the last owner is kept for visibility but never decides a tie.
  logic unused_last_owner;
  assign unused_last_owner = last2_q;
  assign tie_to_2          = 1'b0;
`endif

  // Next state, grant bookkeeping and the registered output values.
  always_comb begin
    state_d   = state_q;
    last2_d   = last2_q;
    timeout_d = 1'b0;
    hold_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (req1 && req2)  state_d = tie_to_2 ? GRANT2 : GRANT1;
        else if (req1)     state_d = GRANT1;
        else if (req2)     state_d = GRANT2;
      end
      GRANT1: begin
        if (done1 || !req1 || wd_hit) begin
          state_d   = TURNAROUND;
          last2_d   = 1'b0;
          timeout_d = req1 && !done1;
        end else begin
          hold_d = (hold_q == '1) ? hold_q : hold_q + CNT_LEN'(1);
        end
      end
      GRANT2: begin
        if (done2 || !req2 || wd_hit) begin
          state_d   = TURNAROUND;
          last2_d   = 1'b1;
          timeout_d = req2 && !done2;
        end else begin
          hold_d = (hold_q == '1) ? hold_q : hold_q + CNT_LEN'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    grant1_d = (state_d == GRANT1);
    grant2_d = (state_d == GRANT2);
    sel_d    = grant1_d ? 2'd1 : (grant2_d ? 2'd2 : 2'd0);
    busy_d   = (state_d != IDLE);
  end

  // State and output registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      last2_q   <= 1'b1;
      grant1_q  <= 1'b0;
      grant2_q  <= 1'b0;
      sel_q     <= 2'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      last2_q   <= last2_d;
      grant1_q  <= grant1_d;
      grant2_q  <= grant2_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
    end
  end

  assign grant1     = grant1_q;
  assign grant2     = grant2_q;
  assign master_sel = sel_q;
  assign bus_busy   = busy_q;
  assign timeout    = timeout_q;
  assign hold_cnt   = hold_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scoreboard bench. Instance A (TIMEOUT=8) is driven by
// directed and random master agents; a reference model pushes the expected
// outputs per cycle and a monitor pops and compares them. Instance B
// (TIMEOUT=0, 8-bit counter) covers watchdog-off saturation and async reset.
module tb_bus_arbiter;

  localparam int unsigned TO_A  = 8;
  localparam int unsigned HMAXA = 65535;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a, req1_a, req2_a, done1_a, done2_a;
  logic        g1_a, g2_a, busy_a, to_a;
  logic [1:0]  sel_a;
  logic [15:0] hold_a;

  logic        reset_b, req1_b, req2_b, done1_b, done2_b;
  logic        g1_b, g2_b, busy_b, to_b;
  logic [1:0]  sel_b;
  logic [7:0]  hold_b;

  bus_arbiter #(.CNT_LEN(16), .TIMEOUT(TO_A)) dut_a (
    .clk(clk), .reset(reset_a), .req1(req1_a), .req2(req2_a),
    .done1(done1_a), .done2(done2_a), .grant1(g1_a), .grant2(g2_a),
    .master_sel(sel_a), .bus_busy(busy_a), .timeout(to_a), .hold_cnt(hold_a)
  );

  bus_arbiter #(.CNT_LEN(8), .TIMEOUT(0)) dut_b (
    .clk(clk), .reset(reset_b), .req1(req1_b), .req2(req2_b),
    .done1(done1_b), .done2(done2_b), .grant1(g1_b), .grant2(g2_b),
    .master_sel(sel_b), .bus_busy(busy_b), .timeout(to_b), .hold_cnt(hold_b)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        g1;
    logic        g2;
    logic [1:0]  sel;
    logic        busy;
    logic        to;
    logic [15:0] hold;
  } obs_t;

  obs_t exp_q[$];

  // Reference model: who owns the bus, for how long, and whether the
  // cycle after a release is being spent in turnaround.
  int m_owner, m_held, m_last;
  bit m_turn, m_to;

  function automatic void model_reset();
    m_owner = 0; m_held = 0; m_last = 2; m_turn = 0; m_to = 0;
  endfunction

  function automatic void model_step(input logic r1, r2, d1, d2);
    bit rel, wd;
    m_to = 0;
    if (m_owner != 0) begin
      rel = (m_owner == 1) ? (d1 || !r1) : (d2 || !r2);
      wd  = (TO_A != 0) && (m_held == int'(TO_A) - 1);
      if (rel || wd) begin
        m_to = !rel; m_last = m_owner; m_owner = 0; m_turn = 1; m_held = 0;
      end else if (m_held < HMAXA) begin
        m_held++;
      end
    end else if (m_turn) begin
      m_turn = 0;
    end else if (r1 || r2) begin
      if (r1 && r2) begin
`ifdef ARB_ROUND_ROBIN_EN
        m_owner = (m_last == 1) ? 2 : 1;
`else
        m_owner = 1;
`endif
      end else begin
        m_owner = r1 ? 1 : 2;
      end
      m_held = 0;
    end
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.g1   = (m_owner == 1);
    o.g2   = (m_owner == 2);
    o.sel  = 2'(m_owner);
    o.busy = (m_owner != 0) || m_turn;
    o.to   = m_to;
    o.hold = (m_owner != 0) ? 16'(m_held) : 16'd0;
    return o;
  endfunction

  // One clock of instance A: model absorbs the inputs the DUT just sampled.
  task automatic tick();
    @(posedge clk); #1;
    model_step(req1_a, req2_a, done1_a, done2_a);
    exp_q.push_back(model_obs());
  endtask

  task automatic set_a(input logic r1, r2, d1, d2);
    req1_a = r1; req2_a = r2; done1_a = d1; done2_a = d2;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compares instance A against the oldest expected entry.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {g1_a, g2_a, sel_a, busy_a, to_a, hold_a};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL arb_outputs at %0t got g1=%0b g2=%0b sel=%0d busy=%0b to=%0b hold=%0d exp g1=%0b g2=%0b sel=%0d busy=%0b to=%0b hold=%0d",
                   $time, a.g1, a.g2, a.sel, a.busy, a.to, a.hold,
                   e.g1, e.g2, e.sel, e.busy, e.to, e.hold);
        end
        checks++;
        if (g1_a && g2_a) begin
          errors++;
          $display("FAIL grant_overlap at %0t got g1=%0b g2=%0b exp not both", $time, g1_a, g2_a);
        end
      end
    end
  end

  int  len [3];
  bit  rq  [3];
  bit  dn  [3];
  bit  drop[3];
  bit  bad;

  initial begin
    reset_a = 1'b1; reset_b = 1'b1;
    set_a(0, 0, 0, 0);
    req1_b = 1'b0; req2_b = 1'b0; done1_b = 1'b0; done2_b = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 exp_q.push_back(model_obs());
    #1 reset_a = 1'b0;

    // Single request, done on its fifth grant cycle.
    tick(); set_a(1, 0, 0, 0);
    repeat (4) begin tick(); set_a(1, 0, 0, 0); end
    tick(); set_a(1, 0, 1, 0);
    repeat (3) begin tick(); set_a(0, 0, 0, 0); end

    // Both requesting continuously; each owner finishes 3 cycles into its grant.
    for (int i = 0; i < 40; i++) begin
      tick();
      set_a(1, 1, (m_owner == 1 && m_held == 3), (m_owner == 2 && m_held == 3));
    end
    repeat (4) begin tick(); set_a(0, 0, 0, 0); end

    // Master 2 never completes: watchdog revokes and it is granted again.
    for (int i = 0; i < 30; i++) begin tick(); set_a(0, 1, 0, 0); end
    repeat (4) begin tick(); set_a(0, 0, 0, 0); end

    // Master 2 asks mid-grant of master 1 and must wait for done1.
    for (int i = 0; i < 20; i++) begin
      tick();
      set_a(i < 7, (i >= 3) && (i < 16), i == 6, (m_owner == 2 && m_held == 2));
    end
    repeat (4) begin tick(); set_a(0, 0, 0, 0); end

    // Random master agents: variable lengths, abandons, stray done pulses.
    for (int k = 0; k < 3; k++) begin rq[k] = 0; dn[k] = 0; drop[k] = 0; len[k] = 0; end
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 1; i <= 2; i++) begin
        dn[i] = 0;
        if (m_owner == i && m_held == 0) len[i] = $urandom_range(0, 11);
        if (m_owner == i && m_held == len[i]) begin
          if ($urandom_range(0, 4) == 0) rq[i] = 0;
          else begin dn[i] = 1; drop[i] = ($urandom_range(0, 1) == 1); end
        end else if (drop[i]) begin
          rq[i] = 0; drop[i] = 0;
        end else if (!rq[i]) begin
          rq[i] = ($urandom_range(0, 2) == 0);
        end
        if (m_owner != i && $urandom_range(0, 7) == 0) dn[i] = 1;
      end
      set_a(rq[1], rq[2], dn[1], dn[2]);
    end
    repeat (5) begin tick(); set_a(0, 0, 0, 0); end
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    // Instance B: watchdog disabled, async reset mid-grant.
    @(posedge clk); #1 reset_b = 1'b0; req1_b = 1'b1;
    repeat (101) @(posedge clk);
    #1;
    chk("b_grant1_held", g1_b, 1);
    chk("b_hold_100", hold_b, 100);
    #1 reset_b = 1'b1;
    #1;
    chk("b_rst_grant1", g1_b, 0);
    chk("b_rst_sel", sel_b, 0);
    chk("b_rst_busy", busy_b, 0);
    chk("b_rst_hold", hold_b, 0);
    @(posedge clk); #1 reset_b = 1'b0; req1_b = 1'b1; req2_b = 1'b1;
    @(posedge clk); #1;
    chk("b_tie_grant1", g1_b, 1);
    chk("b_tie_grant2", g2_b, 0);
    chk("b_tie_sel", sel_b, 1);
    bad = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (to_b || !g1_b || g2_b) bad = 1;
    end
    chk("b_no_watchdog", bad, 0);
    chk("b_hold_saturated", hold_b, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
